// File: rtl/clock_controller.sv
// Clock-enable sequencer for the TD4 core: RUN at one of four rates, single-STEP from a debounced button, or HALT.
// Optional tick counter output enabled by defining CLOCK_CONTROLLER_TICK_COUNT_EN.
module clock_controller #(
  parameter int unsigned DIV0     = 32'd12_000_000,
  parameter int unsigned DIV1     = 32'd1_200_000,
  parameter int unsigned DIV2     = 32'd120_000,
  parameter int unsigned DIV3     = 32'd12,
  parameter int unsigned DEBOUNCE = 32'd120_000
) (
  input  logic        quick_clock,
  input  logic        reset_n,
  input  logic [1:0]  mode,
  input  logic [1:0]  rate_sel,
  input  logic        step_button,
  output logic        cpu_tick,
  output logic        slow_clock,
  output logic        running
`ifdef CLOCK_CONTROLLER_TICK_COUNT_EN
  ,
  output logic [15:0] tick_count
`endif
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE - 1);

  state_t      state;
  state_t      next_state;
  logic [31:0] count;
  logic [31:0] count_nxt;
  logic [31:0] div_m1;
  logic        tick_nxt;

  logic        sync1;
  logic        sync2;
  logic        db_level;
  logic [31:0] db_cnt;
  logic        step_req;

  // Button path: two-flop synchronizer followed by a level debouncer.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge quick_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      db_level <= 1'b0;
      db_cnt   <= '0;
    end else begin
      sync1 <= step_button;
      sync2 <= sync1;
      if (sync2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt >= DB_LAST) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
    end
  end

  // Rising flip of the debounced level, seen on the same edge that performs the flip.
  assign step_req = sync2 && !db_level && (db_cnt >= DB_LAST);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    div_m1 = 32'(DIV0 - 1);
    case (rate_sel)
      2'd1:    div_m1 = 32'(DIV1 - 1);
      2'd2:    div_m1 = 32'(DIV2 - 1);
      2'd3:    div_m1 = 32'(DIV3 - 1);
      default: div_m1 = 32'(DIV0 - 1);
    endcase
  end

  always_comb begin
    next_state = ST_HALT;
    count_nxt  = '0;
    tick_nxt   = 1'b0;

    case (mode)
      2'b01:   next_state = ST_RUN;
      2'b10:   next_state = ST_STEP;
      default: next_state = ST_HALT;
    endcase

    // Count only while staying in RUN; leaving RUN drops any partial period.
    if (state == ST_RUN && next_state == ST_RUN) begin
      if (count >= div_m1) begin
        tick_nxt = 1'b1;
      end else begin
        count_nxt = count + 32'd1;
      end
    end else if (state == ST_STEP && step_req) begin
      tick_nxt = 1'b1;
    end
  end

  always_ff @(posedge quick_clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_HALT;
      running    <= 1'b0;
      count      <= '0;
      cpu_tick   <= 1'b0;
      slow_clock <= 1'b0;
    end else begin
      state      <= next_state;
      running    <= (next_state == ST_RUN);
      count      <= count_nxt;
      cpu_tick   <= tick_nxt;
      slow_clock <= slow_clock ^ tick_nxt;
    end
  end

`ifdef CLOCK_CONTROLLER_TICK_COUNT_EN
  always_ff @(posedge quick_clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_count <= '0;
    end else if (cpu_tick) begin
      tick_count <= tick_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clock_controller.sv
// Self-checking bench for clock_controller: a queue of expected tick cycles is compared against cpu_tick every cycle.
// Defining CLOCK_CONTROLLER_TICK_COUNT_EN adds the tick_count wrap scenario.
module tb_clock_controller;

  localparam int unsigned DIV0     = 4;
  localparam int unsigned DIV1     = 6;
  localparam int unsigned DIV2     = 8;
  localparam int unsigned DIV3     = 2;
  localparam int unsigned DEBOUNCE = 3;

  logic       quick_clock = 1'b0;
  logic       reset_n     = 1'b0;
  logic [1:0] mode        = 2'b00;
  logic [1:0] rate_sel    = 2'b00;
  logic       step_button = 1'b0;
  logic       cpu_tick;
  logic       slow_clock;
  logic       running;
`ifdef CLOCK_CONTROLLER_TICK_COUNT_EN
  logic [15:0] tick_count;
`endif

  int   total = 0;
  int   bad   = 0;
  int   t     = 0;
  int   exp_q[$];
  logic exp_slow = 1'b0;

  always #5 quick_clock = ~quick_clock;

  clock_controller #(
    .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2), .DIV3(DIV3), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .quick_clock(quick_clock),
    .reset_n    (reset_n),
    .mode       (mode),
    .rate_sel   (rate_sel),
    .step_button(step_button),
    .cpu_tick   (cpu_tick),
    .slow_clock (slow_clock),
    .running    (running)
`ifdef CLOCK_CONTROLLER_TICK_COUNT_EN
    ,
    .tick_count (tick_count)
`endif
  );

  // Advance n cycles; each negedge pops the scoreboard if a tick is due and checks cpu_tick/slow_clock.
  task automatic run(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      logic exp_tick;
      @(negedge quick_clock);
      t++;
      exp_tick = (exp_q.size() > 0) && (exp_q[0] == t);
      if (exp_tick) begin
        void'(exp_q.pop_front());
        exp_slow = ~exp_slow;
      end
      total++;
      if (cpu_tick !== exp_tick) begin
        bad++;
        $display("FAIL %s cpu_tick t=%0d: got %b want %b", name, t, cpu_tick, exp_tick);
      end
      total++;
      if (slow_clock !== exp_slow) begin
        bad++;
        $display("FAIL %s slow_clock t=%0d: got %b want %b", name, t, slow_clock, exp_slow);
      end
    end
  endtask

  task automatic drain(input string name);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s missing ticks: got %0d left want 0 (next expected t=%0d)", name, exp_q.size(), exp_q[0]);
    end
    exp_q.delete();
  endtask

  task automatic check_running(input string name, input logic want);
    total++;
    if (running !== want) begin
      bad++;
      $display("FAIL %s running t=%0d: got %b want %b", name, t, running, want);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    mode     = 2'b00;
    rate_sel = 2'b00;
    exp_slow = 1'b0;
    repeat (3) @(negedge quick_clock);
    total += 3;
    if (cpu_tick !== 1'b0)   begin bad++; $display("FAIL reset cpu_tick: got %b want 0", cpu_tick); end
    if (slow_clock !== 1'b0) begin bad++; $display("FAIL reset slow_clock: got %b want 0", slow_clock); end
    if (running !== 1'b0)    begin bad++; $display("FAIL reset running: got %b want 0", running); end
    reset_n = 1'b1;
    t = 0;
    run(3, "reset_idle");
    check_running("reset_idle", 1'b0);
  endtask

  task automatic test_run_rate0();
    mode     = 2'b01;
    rate_sel = 2'd0;
    t = 0;
    // running rises at t=1; first tick DIV0 cycles later, then every DIV0.
    for (int k = 0; k < 4; k++) exp_q.push_back(1 + int'(DIV0) * (k + 1));
    run(1, "run_rate0");
    check_running("run_rate0", 1'b1);
    run(18, "run_rate0");
    drain("run_rate0");
    mode = 2'b00;
    t = 0;
    run(2, "run_rate0_stop");
    check_running("run_rate0_stop", 1'b0);
    drain("run_rate0_stop");
  endtask

  task automatic test_rate_switch();
    mode     = 2'b01;
    rate_sel = 2'd2;
    t = 0;
    // count reaches 5 at t=6; switching to DIV3 then fires at t=7 and every 2 cycles after.
    exp_q.push_back(7);
    exp_q.push_back(9);
    exp_q.push_back(11);
    exp_q.push_back(13);
    exp_q.push_back(15);
    run(6, "rate_switch");
    rate_sel = 2'd3;
    run(9, "rate_switch");
    mode = 2'b00;
    run(3, "rate_switch_stop");
    drain("rate_switch");
  endtask

  task automatic test_step();
    mode = 2'b10;
    t = 0;
    run(3, "step_glitch");
    step_button = 1'b1;
    run(2, "step_glitch");
    step_button = 1'b0;
    run(10, "step_glitch");
    check_running("step", 1'b0);
    // Press at t=15: 2 sync cycles + DEBOUNCE cycles -> tick visible at t=20.
    step_button = 1'b1;
    exp_q.push_back(15 + 2 + int'(DEBOUNCE));
    run(10, "step_press");
    step_button = 1'b0;
    run(15, "step_release");
    drain("step");
  endtask

  task automatic test_halt_discard();
    mode = 2'b00;
    t = 0;
    step_button = 1'b1;
    run(10, "halt_press");
    step_button = 1'b0;
    run(10, "halt_release");
    mode = 2'b11;
    step_button = 1'b1;
    run(10, "mode11_press");
    check_running("mode11", 1'b0);
    mode = 2'b10;
    run(10, "not_queued");
    step_button = 1'b0;
    run(10, "not_queued_release");
    drain("halt_discard");
  endtask

  task automatic test_reset_mid();
    mode     = 2'b01;
    rate_sel = 2'd1;
    t = 0;
    exp_q.push_back(1 + int'(DIV1));
    run(9, "reset_mid_pre");
    drain("reset_mid_pre");
    #2 reset_n = 1'b0;
    #1;
    total += 3;
    if (cpu_tick !== 1'b0)   begin bad++; $display("FAIL async_reset cpu_tick: got %b want 0", cpu_tick); end
    if (slow_clock !== 1'b0) begin bad++; $display("FAIL async_reset slow_clock: got %b want 0", slow_clock); end
    if (running !== 1'b0)    begin bad++; $display("FAIL async_reset running: got %b want 0", running); end
    exp_slow = 1'b0;
    repeat (2) @(negedge quick_clock);
    reset_n = 1'b1;
    t = 0;
    exp_q.push_back(1 + int'(DIV1));
    exp_q.push_back(1 + 2 * int'(DIV1));
    run(1, "reset_mid_post");
    check_running("reset_mid_post", 1'b1);
    run(13, "reset_mid_post");
    drain("reset_mid_post");
    mode = 2'b00;
    t = 0;
    run(2, "reset_mid_stop");
  endtask

`ifdef CLOCK_CONTROLLER_TICK_COUNT_EN
  task automatic test_tick_count();
    logic        saw_wrap = 1'b0;
    logic [15:0] prev     = 16'h0000;
    logic [15:0] want;
    reset_n = 1'b0;
    mode    = 2'b00;
    @(negedge quick_clock);
    total++;
    if (tick_count !== 16'h0000) begin bad++; $display("FAIL tick_count reset: got %h want 0000", tick_count); end
    reset_n  = 1'b1;
    mode     = 2'b01;
    rate_sel = 2'd3;
    t = 0;
    // Ticks visible at t=3,5,...; tick_count lags one cycle, so at sample t it holds floor((t-2)/2).
    for (int i = 0; i < 131075; i++) begin
      @(negedge quick_clock);
      t++;
      if (prev == 16'hFFFF && tick_count == 16'h0000) saw_wrap = 1'b1;
      prev = tick_count;
    end
    want = 16'((t - 2) / 2);
    total += 2;
    if (tick_count !== want) begin bad++; $display("FAIL tick_count value: got %h want %h", tick_count, want); end
    if (saw_wrap !== 1'b1)   begin bad++; $display("FAIL tick_count wrap: got %b want 1", saw_wrap); end
    mode = 2'b00;
    repeat (2) @(negedge quick_clock);
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_run_rate0();
    test_rate_switch();
    test_step();
    test_halt_discard();
    test_reset_mid();
`ifdef CLOCK_CONTROLLER_TICK_COUNT_EN
    test_tick_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
